rd_ptr_ctrl: RTL
================

# rd_ptr_ctrl

Read-side pointer and data-out stage of the FIFO, sitting directly downstream of the read-valid generator in the `rd_clk` domain. It accepts consumer read requests only while the upstream `rd_valid` is high and the FIFO is not empty. On each accepted read it advances the binary/Gray read pointer, fetches the word from the memory read port, and presents it on `dout` with a one-cycle `dout_valid` pulse. It also synchronises the write-domain Gray pointer and derives `empty`.

## Interface
- `FIFO_DEPTH`, default 8: number of storage words; must equal 2**`ADDR_WIDTH`.
- `ADDR_WIDTH`, default 3: memory address width; pointers are `ADDR_WIDTH`+1 bits.
- `DATA_WIDTH`, default 8: data word width.

Ports:
- `rd_clk`  in  1  read-domain clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rd_valid`  in  1  read permission from the upstream valid generator.
- `rd_en`  in  1  consumer read request, level, sampled each `rd_clk` edge.
- `wr_ptr_gray`  in  `ADDR_WIDTH`+1  write pointer (Gray) from the `wr_clk` domain.
- `mem_rd_data`  in  `DATA_WIDTH`  memory asynchronous-read data at `mem_rd_addr`.
- `mem_rd_addr`  out  `ADDR_WIDTH`  memory read address.
- `rd_ptr_gray`  out  `ADDR_WIDTH`+1  registered read pointer (Gray), to the write domain.
- `empty`  out  1  FIFO empty flag.
- `dout`  out  `DATA_WIDTH`  read data.
- `dout_valid`  out  1  one-cycle pulse, `dout` carries a newly read word.
- `rd_reject`  out  1  one-cycle pulse, previous-cycle `rd_en` was not accepted.

## Operation
- `accept` = `rd_en` & `rd_valid` & !`empty` (combinational).
- Read pointer state:
  - `rd_ptr_bin` is `ADDR_WIDTH`+1 bits and increments by 1 on each accept, wrapping modulo 2**(`ADDR_WIDTH`+1) (15 -> 0 at default).
  - `rd_ptr_gray` is registered as bin^(bin>>1) of the next binary value, on the same edge.
- `mem_rd_addr` = `rd_ptr_bin[ADDR_WIDTH-1:0]`, taken from the register output (no combinational path from `rd_en`).
- Write-pointer synchroniser: `wr_ptr_gray` passes through 2 flops (`wp_s1`, `wp_s2`); there is no other logic between the stages.
- `empty` = (`rd_ptr_gray` == `wp_s2`), a combinational compare of registered values.
- Data path: on an accept edge, `mem_rd_data` (addressed by the pre-increment pointer) is captured into the data stage and `dout_valid` is set for exactly one cycle. `dout` holds its last value when there is no accept.
- `rd_reject` is registered as `rd_en` & !`accept`.
- Reset (async, any time, including mid-read):
  - `rd_ptr_bin`, `rd_ptr_gray`, `wp_s1`, `wp_s2`, `mem_rd_addr` = 0.
  - `empty` = 1.
  - `dout` = 0, `dout_valid` = 0, `rd_reject` = 0.
  - Any in-flight output-stage data is discarded.
- Simultaneous `rd_en` and a `wr_ptr_gray` change: `empty` reflects only `wp_s2` as it stood before the edge; the write is not visible in that cycle.

## Timing
- Write to readable: a `wr_ptr_gray` change becomes visible in `empty` after 2 `rd_clk` rising edges.
- Read to write domain: an accept at edge N updates `rd_ptr_gray` immediately after edge N.
- Read latency with `RD_OUT_REG_EN` undefined: accept at edge N -> `dout`/`dout_valid` valid in cycle N+1.
- Back-to-back accepts are sustained at 1 word/cycle until `empty` or `rd_valid` falls.
- The last word drains at full rate: the accept that makes `rd_ptr_gray` equal `wp_s2` raises `empty` in the next cycle, with no extra read.

## Configuration
- `RD_OUT_REG_EN` defined: an extra output register is inserted after the capture stage. `dout`/`dout_valid` then appear in cycle N+2 for an accept at edge N. Throughput is unchanged and reset clears both stages.
- `RD_OUT_REG_EN` undefined: single capture stage with latency 1, as above.

## Test plan
- Reset and idle: assert `reset` mid-cycle with `rd_en`=1 -> `empty`=1, `dout`=0, `dout_valid`=0, `mem_rd_addr`=0 immediately; no accept until 2 edges after `wr_ptr_gray` changes.
- Basic read: `wr_ptr_gray`=4'b0011 (bin 2), memory [0]=8'hA5, [1]=8'h5A, `rd_valid`=1, `rd_en`=1 for 3 cycles -> `dout` A5 then 5A with `dout_valid` pulses in consecutive cycles; third request gives `rd_reject`=1; `empty`=1, `rd_ptr_gray`=4'b0011.
- `rd_valid` gating: `empty`=0, `rd_valid`=0, `rd_en`=1 -> no pointer change, `rd_reject`=1 each cycle, `dout` unchanged.
- Wrap-around: 16 write/read pairs at depth 8 -> `rd_ptr_bin` passes 15 -> 0, `rd_ptr_gray` 4'b1000 -> 4'b0000, data order preserved, `empty`=1 at end.
- Mid-read reset: assert `reset` during a 4-word burst after the 2nd `dout_valid` -> no further `dout_valid`, pointers 0, `empty`=1.
- Latency check with `RD_OUT_REG_EN` defined: a single accept at edge N -> `dout_valid` high only in cycle N+2 with the correct word.

Source files
------------

// File: rtl/rd_ptr_ctrl.sv
// rtl/rd_ptr_ctrl.sv - FIFO read pointer, write-pointer synchroniser and data-out stage
// Optional feature macro: RD_OUT_REG_EN adds a second output register (read latency 2).
module rd_ptr_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  rd_valid,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  rd_reject
);

  localparam int ADDR_MASK = FIFO_DEPTH - 1;

  logic [ADDR_WIDTH:0]   rd_ptr_bin_q, rd_ptr_bin_d;
  logic [ADDR_WIDTH:0]   rd_ptr_gray_q, rd_ptr_gray_d;
  logic [ADDR_WIDTH:0]   wp_s1_q, wp_s2_q;
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
  logic                  cap_valid_q;
  logic                  rd_reject_q;
  logic                  accept;

  // Both operands are registered, so empty never depends on rd_en combinationally.
  assign empty  = (rd_ptr_gray_q == wp_s2_q);
  assign accept = rd_en & rd_valid & ~empty;

  always_comb begin
    rd_ptr_bin_d  = rd_ptr_bin_q;
    rd_ptr_gray_d = rd_ptr_gray_q;
    cap_data_d    = cap_data_q;
    if (accept) begin
      rd_ptr_bin_d  = rd_ptr_bin_q + 1'b1;
      rd_ptr_gray_d = rd_ptr_bin_d ^ (rd_ptr_bin_d >> 1);
      cap_data_d    = mem_rd_data;
    end
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      wp_s1_q       <= '0;
      wp_s2_q       <= '0;
      cap_data_q    <= '0;
      cap_valid_q   <= 1'b0;
      rd_reject_q   <= 1'b0;
    end else begin
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      wp_s1_q       <= wr_ptr_gray;
      wp_s2_q       <= wp_s1_q;
      cap_data_q    <= cap_data_d;
      cap_valid_q   <= accept;
      rd_reject_q   <= rd_en & ~accept;
    end
  end

  assign mem_rd_addr = rd_ptr_bin_q[ADDR_WIDTH-1:0] & ADDR_MASK[ADDR_WIDTH-1:0];
  assign rd_ptr_gray = rd_ptr_gray_q;
  assign rd_reject   = rd_reject_q;

`ifdef RD_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  // Second stage only reloads on a fresh word so dout still holds between reads.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= cap_valid_q;
      if (cap_valid_q) out_data_q <= cap_data_q;
    end
  end

  assign dout       = out_data_q;
  assign dout_valid = out_valid_q;
`else
  assign dout       = cap_data_q;
  assign dout_valid = cap_valid_q;
`endif

endmodule
